pc_gen_ctrl: RTL and testbench

//  Parametrised fetch-PC generator; next generation of the core's PC register.

---
 rtl/pc_gen_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pc_gen_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_ctrl.sv
// pc_gen_ctrl
//   Fetch-PC generator. Registers the fetch address and selects its next value
//   from the interrupt trap, mret, EX redirect, a one-entry pending buffer and
//   the predicted PC, in that priority order. Redirect-type requests that arrive
//   while fetch is stalled are held in the pending buffer until the stall clears.
//   A WFI sleep state parks fetch until an interrupt that is allowed to trap
//   (no handler already active) wakes it.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   PC_in_pred    predicted / sequential next PC
//   redir_valid   EX redirect request, target redir_pc
//   mret, mepc    return-from-handler request and its target
//   interrupt     level interrupt request, irq_cause sampled with it
//   Istall/Dstall I-side / D-side stall; either one freezes fetch
//   wfi           WFI retired; enters sleep on a non-stalled cycle
//   PC_address    registered fetch PC
//   Icache_en     fetch request valid (running and not stalled)
//   trap_taken    one-cycle pulse while PC_address shows the handler PC
//   trap_epc      return PC for the trap, valid with trap_taken
//   in_isr        handler active (set on trap, cleared on mret)
module pc_gen_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h1000_0000,
    parameter logic [XLEN-1:0] TRAP_BASE = 32'h1000_0000,
    parameter int unsigned     VEC_MODE  = 0,
    parameter int unsigned     CAUSE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    PC_in_pred,
    input  logic               redir_valid,
    input  logic [XLEN-1:0]    redir_pc,
    input  logic               mret,
    input  logic [XLEN-1:0]    mepc,
    input  logic               interrupt,
    input  logic [CAUSE_W-1:0] irq_cause,
    input  logic               Istall,
    input  logic               Dstall,
    input  logic               wfi,
    output logic [XLEN-1:0]    PC_address,
    output logic               Icache_en,
    output logic               trap_taken,
    output logic [XLEN-1:0]    trap_epc,
    output logic               in_isr
);

    typedef enum logic [1:0] {BOOT, RUN, SLEEP} state_t;

    // Encoding order is the capture priority: a higher value may overwrite a
    // lower one in the pending buffer.
    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_REDIR = 2'd1,
        P_MRET  = 2'd2,
        P_TRAP  = 2'd3
    } pend_kind_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t            state;
    state_t            state_next;

    pend_kind_t        pend_kind;
    logic [XLEN-1:0]   pend_target;
    logic [XLEN-1:0]   pend_epc;

    logic              stall;
    logic              irq_ok;
    logic [XLEN-1:0]   trap_target;

    // Best source below the interrupt (mret > redirect > pending > predicted).
    logic [XLEN-1:0]   cand_pc;
    logic [XLEN-1:0]   cand_epc;
    logic              cand_trap;
    logic              cand_mret;
    logic [XLEN-1:0]   nt_epc;

    logic [XLEN-1:0]   sel_pc;
    logic [XLEN-1:0]   sel_epc;
    logic              sel_trap;
    logic              sel_mret;

    pend_kind_t        live_kind;
    logic [XLEN-1:0]   live_target;

    assign stall  = Istall | Dstall;
    assign irq_ok = interrupt & ~in_isr;

    always_comb begin
        if (VEC_MODE != 0)
            trap_target = (TRAP_BASE + (XLEN'(irq_cause) << 2)) & ALIGN_MASK;
        else
            trap_target = TRAP_BASE & ALIGN_MASK;
    end

    always_comb begin
        cand_pc   = PC_in_pred;
        cand_epc  = '0;
        cand_trap = 1'b0;
        cand_mret = 1'b0;
        if (mret) begin
            cand_pc   = mepc & ALIGN_MASK;
            cand_mret = 1'b1;
        end else if (redir_valid) begin
            cand_pc = redir_pc & ALIGN_MASK;
        end else begin
            unique case (pend_kind)
                P_REDIR: cand_pc = pend_target;
                P_MRET: begin
                    cand_pc   = pend_target;
                    cand_mret = 1'b1;
                end
                P_TRAP: begin
                    cand_pc   = pend_target;
                    cand_trap = 1'b1;
                    cand_epc  = pend_epc;
                end
                default: ;
            endcase
        end
    end

    // A live trap that supersedes a buffered trap keeps the buffered return PC.
    assign nt_epc = cand_trap ? cand_epc : cand_pc;

    always_comb begin
        if (irq_ok) begin
            sel_pc   = trap_target;
            sel_epc  = nt_epc;
            sel_trap = 1'b1;
            sel_mret = 1'b0;
        end else begin
            sel_pc   = cand_pc;
            sel_epc  = cand_epc;
            sel_trap = cand_trap;
            sel_mret = cand_mret;
        end
    end

    always_comb begin
        live_kind   = P_NONE;
        live_target = '0;
        if (irq_ok) begin
            live_kind   = P_TRAP;
            live_target = trap_target;
        end else if (mret) begin
            live_kind   = P_MRET;
            live_target = mepc & ALIGN_MASK;
        end else if (redir_valid) begin
            live_kind   = P_REDIR;
            live_target = redir_pc & ALIGN_MASK;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:  state_next = RUN;
            RUN:   if (!stall && wfi && !sel_trap) state_next = SLEEP;
            SLEEP: if (irq_ok) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        Icache_en = (state == RUN) && !stall;
    end

    // Fetch PC, trap reporting, handler flag and pending buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_address  <= RESET_VEC - XLEN'(4);
            trap_taken  <= 1'b0;
            trap_epc    <= '0;
            in_isr      <= 1'b0;
            pend_kind   <= P_NONE;
            pend_target <= '0;
            pend_epc    <= '0;
        end else begin
            trap_taken <= 1'b0;
            unique case (state)
                BOOT: PC_address <= RESET_VEC;
                RUN: begin
                    if (!stall) begin
                        PC_address <= sel_pc;
                        pend_kind  <= P_NONE;
                        if (sel_trap) begin
                            trap_taken <= 1'b1;
                            trap_epc   <= sel_epc;
                            in_isr     <= 1'b1;
                        end else if (sel_mret) begin
                            in_isr <= 1'b0;
                        end
                    end else if (live_kind != P_NONE && live_kind >= pend_kind) begin
                        pend_kind   <= live_kind;
                        pend_target <= live_target;
                        pend_epc    <= nt_epc;
                    end
                end
                SLEEP: begin
                    // Waking under a stall parks the trap in the pending buffer
                    // so it applies on the first free cycle even if the level drops.
                    if (irq_ok) begin
                        if (!stall) begin
                            PC_address <= trap_target;
                            trap_taken <= 1'b1;
                            trap_epc   <= PC_in_pred;
                            in_isr     <= 1'b1;
                        end else begin
                            pend_kind   <= P_TRAP;
                            pend_target <= trap_target;
                            pend_epc    <= PC_in_pred;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_ctrl.sv
// tb_pc_gen_ctrl
//   Directed bench for pc_gen_ctrl. Two instances share all inputs except the
//   predicted PC (each gets its own PC+4): one vectored, one direct.
module tb_pc_gen_ctrl;

    logic        clk;
    logic        rst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        mret;
    logic [31:0] mepc;
    logic        interrupt;
    logic [3:0]  irq_cause;
    logic        Istall;
    logic        Dstall;
    logic        wfi;

    logic [31:0] pc,   pred,   tepc;
    logic        ic_en, tt, isr;
    logic [31:0] pc_d, pred_d, tepc_d;
    logic        ic_en_d, tt_d, isr_d;

    int n_checks = 0;
    int n_errors = 0;

    assign pred   = pc + 32'd4;
    assign pred_d = pc_d + 32'd4;

    pc_gen_ctrl #(
        .XLEN(32), .RESET_VEC(32'h1000_0000), .TRAP_BASE(32'h1000_0000),
        .VEC_MODE(1), .CAUSE_W(4)
    ) dut (
        .clk(clk), .rst(rst), .PC_in_pred(pred),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .mret(mret), .mepc(mepc), .interrupt(interrupt), .irq_cause(irq_cause),
        .Istall(Istall), .Dstall(Dstall), .wfi(wfi),
        .PC_address(pc), .Icache_en(ic_en), .trap_taken(tt),
        .trap_epc(tepc), .in_isr(isr)
    );

    pc_gen_ctrl #(
        .XLEN(32), .RESET_VEC(32'h1000_0000), .TRAP_BASE(32'h1000_0000),
        .VEC_MODE(0), .CAUSE_W(4)
    ) dut_d (
        .clk(clk), .rst(rst), .PC_in_pred(pred_d),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .mret(mret), .mepc(mepc), .interrupt(interrupt), .irq_cause(irq_cause),
        .Istall(Istall), .Dstall(Dstall), .wfi(wfi),
        .PC_address(pc_d), .Icache_en(ic_en_d), .trap_taken(tt_d),
        .trap_epc(tepc_d), .in_isr(isr_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; mret = 1'b0; mepc = '0;
        interrupt = 1'b0; irq_cause = '0; Istall = 1'b0; Dstall = 1'b0; wfi = 1'b0;

        // Reset and boot sequence
        tick();
        check("rst_pc",   pc,          32'h0FFF_FFFC);
        check("rst_ic",   32'(ic_en),  32'd0);
        check("rst_tt",   32'(tt),     32'd0);
        check("rst_tepc", tepc,        32'd0);
        check("rst_isr",  32'(isr),    32'd0);
        rst = 1'b0;
        tick();
        check("boot_pc", pc,         32'h1000_0000);
        check("boot_ic", 32'(ic_en), 32'd1);
        tick();
        check("seq_pc", pc,         32'h1000_0004);
        check("seq_ic", 32'(ic_en), 32'd1);

        // Redirect during a 3-cycle stall, misaligned target
        Istall = 1'b1;
        tick();
        check("stall1_pc", pc,         32'h1000_0004);
        check("stall1_ic", 32'(ic_en), 32'd0);
        redir_valid = 1'b1; redir_pc = 32'h0000_2002;
        tick();
        check("stall2_pc", pc, 32'h1000_0004);
        redir_valid = 1'b0;
        tick();
        check("stall3_pc", pc, 32'h1000_0004);
        Istall = 1'b0;
        tick();
        check("pend_redir_pc", pc,         32'h0000_2000);
        check("pend_redir_ic", 32'(ic_en), 32'd1);
        tick();
        check("post_redir_pc", pc, 32'h0000_2004);

        // Lower-priority redirect dropped behind a buffered mret
        Dstall = 1'b1; mret = 1'b1; mepc = 32'h0000_3000;
        tick();
        mret = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0000_4000;
        tick();
        check("drop_hold_pc", pc, 32'h0000_2004);
        redir_valid = 1'b0; Dstall = 1'b0;
        tick();
        check("drop_pc", pc, 32'h0000_3000);

        // Vectored trap, cause 3
        redir_valid = 1'b1; redir_pc = 32'h1000_0010;
        tick();
        redir_valid = 1'b0;
        check("pre_trap_pc", pc, 32'h1000_0010);
        interrupt = 1'b1; irq_cause = 4'd3;
        tick();
        check("vtrap_pc",    pc,        32'h1000_000C);
        check("vtrap_tt",    32'(tt),   32'd1);
        check("vtrap_epc",   tepc,      32'h1000_0014);
        check("vtrap_isr",   32'(isr),  32'd1);
        check("dtrap_pc",    pc_d,      32'h1000_0000);
        check("dtrap_epc",   tepc_d,    32'h1000_0014);
        tick();
        check("trap_pulse_tt", 32'(tt),  32'd0);
        check("isr_hold",      32'(isr), 32'd1);
        check("isr_seq_pc",    pc,       32'h1000_0010);

        // mret and interrupt together while in the handler
        mret = 1'b1; mepc = 32'h1000_0014;
        tick();
        check("mret_pc",  pc,       32'h1000_0014);
        check("mret_isr", 32'(isr), 32'd0);
        check("mret_tt",  32'(tt),  32'd0);
        mret = 1'b0;
        tick();
        check("retrap_pc",  pc,       32'h1000_000C);
        check("retrap_tt",  32'(tt),  32'd1);
        check("retrap_epc", tepc,     32'h1000_0018);
        check("retrap_isr", 32'(isr), 32'd1);
        interrupt = 1'b0;
        mret = 1'b1; mepc = 32'h1000_0018;
        tick();
        mret = 1'b0;

        // WFI sleep, ignored redirect, wake on interrupt (cause 0 -> TRAP_BASE)
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        check("wfi_pc", pc,         32'h1000_001C);
        check("wfi_ic", 32'(ic_en), 32'd0);
        redir_valid = 1'b1; redir_pc = 32'h0000_5000;
        tick();
        redir_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sleep_pc", pc,         32'h1000_001C);
        check("sleep_ic", 32'(ic_en), 32'd0);
        interrupt = 1'b1; irq_cause = 4'd0;
        tick();
        interrupt = 1'b0;
        check("wake_pc",  pc,         32'h1000_0000);
        check("wake_tt",  32'(tt),    32'd1);
        check("wake_epc", tepc,       32'h1000_0020);
        check("wake_ic",  32'(ic_en), 32'd1);

        // Wake under a stall: trap is deferred, not lost
        mret = 1'b1; mepc = 32'h1000_0020;
        tick();
        mret = 1'b0; wfi = 1'b1;
        tick();
        wfi = 1'b0;
        interrupt = 1'b1; Istall = 1'b1;
        tick();
        interrupt = 1'b0;
        check("swake_hold_tt", 32'(tt), 32'd0);
        tick();
        check("swake_hold_pc", pc,         32'h1000_0024);
        check("swake_hold_ic", 32'(ic_en), 32'd0);
        Istall = 1'b0;
        tick();
        check("swake_pc",  pc,       32'h1000_0000);
        check("swake_tt",  32'(tt),  32'd1);
        check("swake_epc", tepc,     32'h1000_0028);
        check("swake_isr", 32'(isr), 32'd1);

        // Reset during a stall with a buffered redirect
        Istall = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0000_6000;
        tick();
        redir_valid = 1'b0; rst = 1'b1;
        tick();
        check("rst2_pc",   pc,         32'h0FFF_FFFC);
        check("rst2_ic",   32'(ic_en), 32'd0);
        check("rst2_isr",  32'(isr),   32'd0);
        check("rst2_tepc", tepc,       32'd0);
        rst = 1'b0; Istall = 1'b0;
        tick();
        check("rst2_boot_pc", pc, 32'h1000_0000);
        tick();
        check("rst2_seq_pc", pc, 32'h1000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
